// File: rtl/acceltran_pkg.sv
// Shared fixed-point and tile types for the accelerator datapath blocks.
package acceltran_pkg;

  localparam int IL_DEFAULT  = 4;
  localparam int FL_DEFAULT  = 16;
  localparam int ROW_DEFAULT = 16;
  localparam int COL_DEFAULT = 256;
  localparam int FXP_W       = IL_DEFAULT + FL_DEFAULT;

  typedef logic signed [FXP_W-1:0] fxp_t;
  typedef fxp_t [COL_DEFAULT-1:0] row_vec_t;
  typedef row_vec_t [ROW_DEFAULT-1:0] tile_t;

endpackage

// File: rtl/tile_bank.sv
// One staging bank: row-indexed write, whole-tile parallel read, rows-written count.
module tile_bank
  import acceltran_pkg::*;
#(
  parameter int ROWS  = ROW_DEFAULT,
  parameter int COLS  = COL_DEFAULT,
  parameter int W     = FXP_W,
  parameter int IDX_W = 4,
  parameter int CNT_W = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_idx,
  input  logic [COLS-1:0][W-1:0]           wr_data,
  input  logic                             close,
  input  logic [CNT_W-1:0]                 close_rows,
  input  logic                             clear,
  output logic [ROWS-1:0][COLS-1:0][W-1:0] data,
  output logic [CNT_W-1:0]                 rows
);

  // Clear zeroes the whole bank so unwritten rows of a short tile read as 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      rows <= '0;
    end else if (clear) begin
      data <= '0;
      rows <= '0;
    end else begin
      if (wr_en) data[wr_idx] <= wr_data;
      if (close) rows <= close_rows;
    end
  end

endmodule

// File: rtl/tile_assembler.sv
// Row-to-tile staging buffer: ping-pong banks assemble rows into tiles for the transposer.
module tile_assembler
  import acceltran_pkg::*;
#(
  parameter int IL  = IL_DEFAULT,
  parameter int FL  = FL_DEFAULT,
  parameter int row = ROW_DEFAULT,
  parameter int col = COL_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [col-1:0][IL+FL-1:0]            in_row,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_taken,
  output logic [row-1:0][col-1:0][IL+FL-1:0]   out,
  output logic [$clog2(row+1)-1:0]             out_rows,
  output logic [1:0]                           occupancy
);

  localparam int W     = IL + FL;
  localparam int IDX_W = (row > 1) ? $clog2(row) : 1;
  localparam int CNT_W = $clog2(row + 1);

  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] row_cnt;
  logic [1:0]       bank_full;

  logic accept;
  logic close;
  logic rel;

  logic [1:0][row-1:0][col-1:0][W-1:0] bank_data;
  logic [1:0][CNT_W-1:0]               bank_rows;

  assign in_ready  = !bank_full[wr_bank];
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || (row_cnt == IDX_W'(row - 1)));
  assign out_valid = bank_full[rd_bank];
  assign rel       = out_taken && out_valid;

  // A partially filled read bank must not leak onto out before it closes.
  assign out       = out_valid ? bank_data[rd_bank] : '0;
  assign out_rows  = out_valid ? bank_rows[rd_bank] : '0;
  assign occupancy = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_bank #(
      .ROWS (row),
      .COLS (col),
      .W    (W),
      .IDX_W(IDX_W),
      .CNT_W(CNT_W)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (accept && (wr_bank == 1'(b))),
      .wr_idx    (row_cnt),
      .wr_data   (in_row),
      .close     (close && (wr_bank == 1'(b))),
      .close_rows(CNT_W'(row_cnt) + CNT_W'(1)),
      .clear     (rel && (rd_bank == 1'(b))),
      .data      (bank_data[b]),
      .rows      (bank_rows[b])
    );
  end

  // Close and release never hit the same bank: closing needs an empty write bank,
  // releasing needs a full read bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      row_cnt   <= '0;
      bank_full <= 2'b00;
    end else begin
      if (accept) begin
        if (close) begin
          row_cnt <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          row_cnt <= row_cnt + IDX_W'(1);
        end
      end
      if (close) bank_full[wr_bank] <= 1'b1;
      if (rel) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
    end
  end

endmodule
